// File: rtl/mips_boot_loader.sv
// rtl/mips_boot_loader.sv - framed byte-stream loader writing instruction memory for the MIPS core
module mips_boot_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          MAX_WORDS = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   output logic        core_rst_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [15:0] words_loaded_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR_HI, S_HDR_LO, S_PAYLOAD, S_CHECK, S_DONE, S_ERR
   } state_t;

   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

   state_t      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [15:0] word_idx_q, word_idx_d;
   logic [7:0]  csum_q, csum_d;
   logic [23:0] asm_q, asm_d;
   logic        ready_q, ready_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wd_q, wd_d;
   logic        core_rst_q, core_rst_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [15:0] loaded_q, loaded_d;

   logic        accept;
   logic [15:0] hdr;
   logic        busy_next;

   assign accept = byte_valid_i & ready_q;
   assign hdr    = {count_q[15:8], byte_data_i};

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      byte_idx_d = byte_idx_q;
      word_idx_d = word_idx_q;
      csum_d     = csum_q;
      asm_d      = asm_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wd_d       = wd_q;
      loaded_d   = loaded_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start_i) begin
               state_d    = S_HDR_HI;
               count_d    = 16'h0;
               byte_idx_d = 2'd0;
               word_idx_d = 16'h0;
               csum_d     = 8'h0;
               loaded_d   = 16'h0;
            end
         end
         S_HDR_HI: begin
            if (accept) begin
               count_d[15:8] = byte_data_i;
               state_d       = S_HDR_LO;
            end
         end
         S_HDR_LO: begin
            if (accept) begin
               count_d[7:0] = byte_data_i;
               if (hdr == 16'h0 || {1'b0, hdr} > MAX_W) state_d = S_ERR;
               else                                   state_d = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (accept) begin
               csum_d     = csum_q ^ byte_data_i;
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: asm_d[7:0]   = byte_data_i;
                  2'd1: asm_d[15:8]  = byte_data_i;
                  2'd2: asm_d[23:16] = byte_data_i;
                  default: begin
                     we_d       = 1'b1;
                     addr_d     = BASE_ADDR + {14'h0, word_idx_q, 2'b00};
                     wd_d       = {byte_data_i, asm_q};
                     word_idx_d = word_idx_q + 16'd1;
                     loaded_d   = loaded_q + 16'd1;
                     if (word_idx_q + 16'd1 == count_q) state_d = S_CHECK;
                  end
               endcase
            end
         end
         S_CHECK: begin
            if (accept) state_d = (byte_data_i == csum_q) ? S_DONE : S_ERR;
         end
         default: state_d = S_IDLE;
      endcase
      busy_next  = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
                   (state_d == S_PAYLOAD) || (state_d == S_CHECK);
      ready_d    = busy_next;
      busy_d     = busy_next;
      done_d     = (state_d == S_DONE);
      err_d      = (state_d == S_ERR);
      core_rst_d = (state_d != S_DONE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         count_q    <= 16'h0;
         byte_idx_q <= 2'd0;
         word_idx_q <= 16'h0;
         csum_q     <= 8'h0;
         asm_q      <= 24'h0;
         ready_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= BASE_ADDR;
         wd_q       <= 32'h0;
         core_rst_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         loaded_q   <= 16'h0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         byte_idx_q <= byte_idx_d;
         word_idx_q <= word_idx_d;
         csum_q     <= csum_d;
         asm_q      <= asm_d;
         ready_q    <= ready_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wd_q       <= wd_d;
         core_rst_q <= core_rst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         loaded_q   <= loaded_d;
      end
   end

   assign byte_ready_o   = ready_q;
   assign mem_we_o       = we_q;
   assign mem_addr_o     = addr_q;
   assign mem_wd_o       = wd_q;
   assign core_rst_o     = core_rst_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign err_o          = err_q;
   assign words_loaded_o = loaded_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// tb/tb_mips_boot_loader.sv - self-checking bench for mips_boot_loader
module tb_mips_boot_loader;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        byte_valid_i = 1'b0;
   logic [7:0]  byte_data_i = 8'h0;
   logic        byte_ready_o, mem_we_o, core_rst_o, busy_o, done_o, err_o;
   logic [31:0] mem_addr_o, mem_wd_o;
   logic [15:0] words_loaded_o;

   mips_boot_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(64)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
      .byte_ready_o(byte_ready_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
      .core_rst_o(core_rst_o), .busy_o(busy_o), .done_o(done_o),
      .err_o(err_o), .words_loaded_o(words_loaded_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Expected frame outcome, derived from the byte list alone
   logic [7:0]  frame [$];
   logic [31:0] exp_addr [0:63];
   logic [31:0] exp_wd   [0:63];
   int          exp_n = 0;
   bit          exp_done = 0;
   logic [7:0]  exp_csum = 8'h0;

   int writes_seen = 0;
   int clr_gen = 0;
   int clr_seen = 0;
   bit chk_en = 0;

   task automatic check(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic void build_model();
      int cnt;
      int last;
      cnt = {frame[0], frame[1]};
      exp_n = (cnt == 0 || cnt > 64) ? 0 : cnt;
      exp_csum = 8'h0;
      for (int w = 0; w < exp_n; w++) begin
         exp_addr[w] = 32'h0 + 32'(4 * w);
         exp_wd[w] = {frame[2+4*w+3], frame[2+4*w+2], frame[2+4*w+1], frame[2+4*w]};
         for (int k = 0; k < 4; k++) exp_csum = exp_csum ^ frame[2+4*w+k];
      end
      last = 2 + 4 * exp_n;
      exp_done = (exp_n > 0) && (frame.size() > last) && (frame[last] == exp_csum);
   endfunction

   // Per-cycle comparison against the model, sampled on the falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         if (clr_gen != clr_seen) begin
            clr_seen = clr_gen;
            writes_seen = 0;
         end
         if (mem_we_o) begin
            if (writes_seen < exp_n) begin
               check(mem_addr_o == exp_addr[writes_seen], "write_addr", mem_addr_o, exp_addr[writes_seen]);
               check(mem_wd_o == exp_wd[writes_seen], "write_data", mem_wd_o, exp_wd[writes_seen]);
            end else begin
               check(1'b0, "unexpected_write", writes_seen, exp_n);
            end
            writes_seen++;
         end
         check(words_loaded_o == 16'(writes_seen), "words_loaded", words_loaded_o, writes_seen);
         check(byte_ready_o == busy_o, "ready_vs_busy", byte_ready_o, busy_o);
         check(core_rst_o == !done_o, "core_rst_vs_done", core_rst_o, !done_o);
         check(!(done_o && err_o), "done_and_err", {done_o, err_o}, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      clr_gen++;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap, output bit ok);
      if (gap) begin
         byte_valid_i = 1'b0;
         tick();
      end
      byte_valid_i = 1'b1;
      byte_data_i = b;
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         if (byte_ready_o) ok = 1'b1;
         tick();
      end
      byte_valid_i = 1'b0;
   endtask

   task automatic send_frame(input int nbytes, input bit gap);
      bit ok;
      for (int i = 0; i < nbytes; i++) begin
         send_byte(frame[i], gap, ok);
         if (!ok) begin
            check(1'b0, "byte_accept_timeout", i, nbytes);
            return;
         end
      end
   endtask

   task automatic finish_check(input string name);
      tick();
      tick();
      check(done_o == exp_done, {name, "_done"}, done_o, exp_done);
      check(err_o == !exp_done, {name, "_err"}, err_o, !exp_done);
      check(core_rst_o == !exp_done, {name, "_core_rst"}, core_rst_o, !exp_done);
      check(busy_o == 1'b0, {name, "_busy"}, busy_o, 0);
      check(words_loaded_o == 16'(exp_n), {name, "_words_loaded"}, words_loaded_o, exp_n);
      check(writes_seen == exp_n, {name, "_writes_seen"}, writes_seen, exp_n);
   endtask

   task automatic load_good_frame();
      frame = '{8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
      build_model();
   endtask

   initial begin
      int ws;
      // 1: reset held two cycles
      rst_i = 1'b1;
      tick();
      tick();
      check(byte_ready_o == 1'b0, "rst_ready", byte_ready_o, 0);
      check(mem_we_o == 1'b0, "rst_we", mem_we_o, 0);
      check(mem_addr_o == 32'h0, "rst_addr", mem_addr_o, 0);
      check(mem_wd_o == 32'h0, "rst_wd", mem_wd_o, 0);
      check(core_rst_o == 1'b1, "rst_core_rst", core_rst_o, 1);
      check({busy_o, done_o, err_o} == 3'b000, "rst_flags", {busy_o, done_o, err_o}, 0);
      check(words_loaded_o == 16'h0, "rst_words", words_loaded_o, 0);
      rst_i = 1'b0;
      chk_en = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      // 2: good load
      load_good_frame();
      check(exp_wd[0] == 32'h12345678, "model_word0", exp_wd[0], 32'h12345678);
      check(exp_wd[1] == 32'hDEADBEEF, "model_word1", exp_wd[1], 32'hDEADBEEF);
      check(exp_csum == 8'h2A, "model_csum", exp_csum, 8'h2A);
      start_load();
      send_frame(11, 1'b0);
      finish_check("good");
      check(done_o == 1'b1 && core_rst_o == 1'b0, "good_literal", {done_o, core_rst_o}, 2'b10);
      check(mem_addr_o == 32'h4, "hold_addr", mem_addr_o, 32'h4);
      check(mem_wd_o == 32'hDEADBEEF, "hold_wd", mem_wd_o, 32'hDEADBEEF);

      // 3: bad checksum
      load_good_frame();
      frame[10] = 8'h00;
      build_model();
      start_load();
      send_frame(11, 1'b0);
      finish_check("badsum");
      check(err_o == 1'b1 && core_rst_o == 1'b1, "badsum_literal", {err_o, core_rst_o}, 2'b11);

      // 4: zero count, then count above MAX_WORDS
      frame = '{8'h00, 8'h00};
      build_model();
      start_load();
      send_frame(2, 1'b0);
      finish_check("hdr_zero");
      frame = '{8'h00, 8'h41};
      build_model();
      start_load();
      send_frame(2, 1'b0);
      finish_check("hdr_big");
      check(err_o == 1'b1 && words_loaded_o == 16'h0, "hdr_big_literal", {err_o, words_loaded_o}, 17'h10000);

      // 5: gapped stream, then bytes offered in DONE
      load_good_frame();
      start_load();
      send_frame(11, 1'b1);
      finish_check("gapped");
      byte_valid_i = 1'b1;
      byte_data_i = 8'h55;
      for (int i = 0; i < 4; i++) begin
         check(byte_ready_o == 1'b0, "done_ready", byte_ready_o, 0);
         tick();
      end
      byte_valid_i = 1'b0;
      tick();
      check(done_o == 1'b1 && words_loaded_o == 16'd2, "done_ignores_bytes", {done_o, words_loaded_o}, 17'h10002);

      // 6: reset after five payload bytes, then a fresh load
      load_good_frame();
      start_load();
      send_frame(7, 1'b0);
      rst_i = 1'b1;
      tick();
      ws = writes_seen;
      clr_gen++;
      rst_i = 1'b0;
      check(ws == 1, "midload_one_write", ws, 1);
      tick();
      check(busy_o == 1'b0 && core_rst_o == 1'b1, "midload_idle", {busy_o, core_rst_o}, 2'b01);
      check(words_loaded_o == 16'h0, "midload_words", words_loaded_o, 0);
      start_load();
      send_frame(11, 1'b0);
      finish_check("reload");

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
